iommu_ddtc_ctrl: RTL and testbench

- Sequences device-context (DC) resolution for the IOMMU translation path: accepts device_id requests, probes the DDTC, and on a miss fetches the DC from a single-level DDT in memory.
- Fills the DDTC with the fetched DC and returns the DC, or a fault cause, to the requester.
- Also serialises IODIR.INVAL_DDT commands from the command queue into DDTC flush pulses.

---
 rtl/iommu_ddtc_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_iommu_ddtc_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/iommu_ddtc_ctrl.sv
// Device-context resolution sequencer: probes the DDTC, walks a single-level DDT on a miss,
// fills the DDTC and answers the requester; also turns IODIR.INVAL_DDT commands into flush pulses.
module iommu_ddtc_ctrl #(
  parameter  int DC_WORDS = 4,
  parameter  int DID_BITS = 7,
  parameter  int PA_W     = 56,
  localparam int DC_W     = DC_WORDS * 64
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [23:0]       req_did_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [DC_W-1:0]   resp_dc_o,
  output logic              resp_fault_o,
  output logic [11:0]       resp_cause_o,
  input  logic              inval_valid_i,
  output logic              inval_ready_o,
  input  logic              inval_dv_i,
  input  logic [23:0]       inval_did_i,
  input  logic [PA_W-1:0]   ddt_base_i,
  output logic              flush_o,
  output logic              flush_dv_o,
  output logic [23:0]       flush_did_o,
  output logic              update_o,
  output logic [23:0]       up_did_o,
  output logic [DC_W-1:0]   up_content_o,
  output logic              lookup_o,
  output logic [23:0]       lu_did_o,
  input  logic              lu_hit_i,
  input  logic [DC_W-1:0]   lu_content_i,
  output logic              mem_ar_valid_o,
  input  logic              mem_ar_ready_i,
  output logic [PA_W-1:0]   mem_ar_addr_o,
  output logic [7:0]        mem_ar_len_o,
  input  logic              mem_r_valid_i,
  output logic              mem_r_ready_o,
  input  logic [63:0]       mem_r_data_i,
  input  logic              mem_r_last_i,
  input  logic              mem_r_err_i
);

  localparam int CNT_W = $clog2(DC_WORDS + 1);

  typedef enum logic [2:0] {IDLE, LOOKUP, AR, R, UPDATE, RESP} state_e;

  state_e             state_reg, state_next;
  logic [23:0]        did_reg, did_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               err_reg, err_next;
  logic               fault_reg, fault_next;
  logic [11:0]        cause_reg, cause_next;
  logic [63:0]        word_reg [DC_WORDS];
  logic [DC_W-1:0]    dc_flat;
  logic               did_ok, hit_load, beat_we, short_burst, v_bit;

  assign did_ok      = (did_reg[23:DID_BITS] == '0);
  assign hit_load    = (state_reg == LOOKUP) && did_ok && lu_hit_i;
  assign beat_we     = (state_reg == R) && mem_r_valid_i && (cnt_reg < CNT_W'(DC_WORDS));
  // Counted before this beat, so the closing beat itself brings the total to cnt_reg+1.
  assign short_burst = (cnt_reg < CNT_W'(DC_WORDS - 1));
  assign v_bit       = (cnt_reg == '0) ? mem_r_data_i[0] : word_reg[0][0];

  for (genvar gi = 0; gi < DC_WORDS; gi++) begin : g_word
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        word_reg[gi] <= '0;
      end else if (hit_load) begin
        word_reg[gi] <= lu_content_i[gi*64 +: 64];
      end else if (beat_we && (cnt_reg == CNT_W'(gi))) begin
        word_reg[gi] <= mem_r_data_i;
      end
    end
    assign dc_flat[gi*64 +: 64] = word_reg[gi];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= IDLE;
      did_reg   <= '0;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
      fault_reg <= 1'b0;
      cause_reg <= '0;
    end else begin
      state_reg <= state_next;
      did_reg   <= did_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
      fault_reg <= fault_next;
      cause_reg <= cause_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    did_next       = did_reg;
    cnt_next       = cnt_reg;
    err_next       = err_reg;
    fault_next     = fault_reg;
    cause_next     = cause_reg;
    req_ready_o    = 1'b0;
    inval_ready_o  = 1'b0;
    flush_o        = 1'b0;
    lookup_o       = 1'b0;
    mem_ar_valid_o = 1'b0;
    mem_r_ready_o  = 1'b0;
    update_o       = 1'b0;
    resp_valid_o   = 1'b0;
    case (state_reg)
      IDLE: begin
        inval_ready_o = 1'b1;
        req_ready_o   = !inval_valid_i;
        if (inval_valid_i) begin
          flush_o = 1'b1;
        end else if (req_valid_i) begin
          did_next   = req_did_i;
          fault_next = 1'b0;
          cause_next = '0;
          state_next = LOOKUP;
        end
      end
      LOOKUP: begin
        lookup_o = 1'b1;
        if (!did_ok) begin
          fault_next = 1'b1;
          cause_next = 12'd258;
          state_next = RESP;
        end else if (lu_hit_i) begin
          state_next = RESP;
        end else begin
          state_next = AR;
        end
      end
      AR: begin
        mem_ar_valid_o = 1'b1;
        if (mem_ar_ready_i) begin
          cnt_next   = '0;
          err_next   = 1'b0;
          state_next = R;
        end
      end
      R: begin
        mem_r_ready_o = 1'b1;
        if (mem_r_valid_i) begin
          if (beat_we) cnt_next = cnt_reg + 1'b1;
          err_next = err_reg | mem_r_err_i;
          if (mem_r_last_i) begin
            if (err_reg || mem_r_err_i || short_burst) begin
              fault_next = 1'b1;
              cause_next = 12'd257;
              state_next = RESP;
            end else if (!v_bit) begin
              fault_next = 1'b1;
              cause_next = 12'd258;
              state_next = RESP;
            end else begin
              state_next = UPDATE;
            end
          end
        end
      end
      UPDATE: begin
        update_o   = 1'b1;
        state_next = RESP;
      end
      RESP: begin
        resp_valid_o = 1'b1;
        if (resp_ready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign flush_dv_o    = flush_o & inval_dv_i;
  assign flush_did_o   = flush_o ? inval_did_i : '0;
  assign lu_did_o      = did_reg;
  assign up_did_o      = did_reg;
  assign up_content_o  = dc_flat;
  assign mem_ar_addr_o = ddt_base_i + PA_W'(did_reg[DID_BITS-1:0]) * PA_W'(DC_WORDS * 8);
  assign mem_ar_len_o  = 8'(DC_WORDS - 1);
  assign resp_dc_o     = fault_reg ? '0 : dc_flat;
  assign resp_fault_o  = fault_reg;
  assign resp_cause_o  = cause_reg;

endmodule

// File: tb/tb_iommu_ddtc_ctrl.sv
// Directed bench for iommu_ddtc_ctrl: inval priority, DDTC hit, DDT walks, faults, backpressure, reset abort.
module tb_iommu_ddtc_ctrl;
  localparam int DC_WORDS = 4;
  localparam int DC_W = DC_WORDS * 64;
  localparam int PA_W = 56;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic req_valid_i = 0, resp_ready_i = 0, inval_valid_i = 0, inval_dv_i = 0;
  logic [23:0] req_did_i = '0, inval_did_i = '0;
  logic [PA_W-1:0] ddt_base_i = 56'h8000_0000;
  logic lu_hit_i = 0;
  logic [DC_W-1:0] lu_content_i = '0;
  logic mem_ar_ready_i = 0, mem_r_valid_i = 0, mem_r_last_i = 0, mem_r_err_i = 0;
  logic [63:0] mem_r_data_i = '0;
  logic req_ready_o, resp_valid_o, resp_fault_o, inval_ready_o;
  logic [DC_W-1:0] resp_dc_o, up_content_o;
  logic [11:0] resp_cause_o;
  logic flush_o, flush_dv_o, update_o, lookup_o, mem_ar_valid_o, mem_r_ready_o;
  logic [23:0] flush_did_o, up_did_o, lu_did_o;
  logic [PA_W-1:0] mem_ar_addr_o;
  logic [7:0] mem_ar_len_o;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] beat_words [DC_WORDS];
  int err_beat = -1;

  localparam logic [DC_W-1:0] HIT_DC = {64'hDEAD_BEEF_0000_0004, 64'hDEAD_BEEF_0000_0003,
                                         64'hDEAD_BEEF_0000_0002, 64'hDEAD_BEEF_0000_0001};

  always #5 clk_i = ~clk_i;

  iommu_ddtc_ctrl #(.DC_WORDS(DC_WORDS), .DID_BITS(7), .PA_W(PA_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_did_i(req_did_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_dc_o(resp_dc_o),
    .resp_fault_o(resp_fault_o), .resp_cause_o(resp_cause_o),
    .inval_valid_i(inval_valid_i), .inval_ready_o(inval_ready_o), .inval_dv_i(inval_dv_i),
    .inval_did_i(inval_did_i), .ddt_base_i(ddt_base_i),
    .flush_o(flush_o), .flush_dv_o(flush_dv_o), .flush_did_o(flush_did_o),
    .update_o(update_o), .up_did_o(up_did_o), .up_content_o(up_content_o),
    .lookup_o(lookup_o), .lu_did_o(lu_did_o), .lu_hit_i(lu_hit_i), .lu_content_i(lu_content_i),
    .mem_ar_valid_o(mem_ar_valid_o), .mem_ar_ready_i(mem_ar_ready_i),
    .mem_ar_addr_o(mem_ar_addr_o), .mem_ar_len_o(mem_ar_len_o),
    .mem_r_valid_i(mem_r_valid_i), .mem_r_ready_o(mem_r_ready_o), .mem_r_data_i(mem_r_data_i),
    .mem_r_last_i(mem_r_last_i), .mem_r_err_i(mem_r_err_i)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Presents one request for a single cycle; the cycle it is presented in is cycle N.
  task automatic issue_req(input logic [23:0] did);
    req_valid_i = 1'b1;
    req_did_i   = did;
    step();
    req_valid_i = 1'b0;
  endtask

  // Zero-wait read data: one beat per cycle from beat_words, error on beat index err_beat.
  task automatic drive_beats();
    for (int i = 0; i < DC_WORDS; i++) begin
      mem_r_valid_i = 1'b1;
      mem_r_data_i  = beat_words[i];
      mem_r_err_i   = (i == err_beat);
      mem_r_last_i  = (i == DC_WORDS - 1);
      step();
    end
    mem_r_valid_i = 1'b0;
    mem_r_last_i  = 1'b0;
    mem_r_err_i   = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (resp_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_resp_valid got=%b want=0", resp_valid_o); end
    n_cmp++; if ({flush_o, update_o, lookup_o, mem_ar_valid_o} !== 4'b0) begin n_bad++; $display("FAIL reset_pulses got=%b want=0000", {flush_o, update_o, lookup_o, mem_ar_valid_o}); end
    n_cmp++; if ({resp_fault_o, resp_cause_o} !== 13'd0) begin n_bad++; $display("FAIL reset_fault got=%b/%0d want=0/0", resp_fault_o, resp_cause_o); end
    n_cmp++; if (resp_dc_o !== '0) begin n_bad++; $display("FAIL reset_dc got=%h want=0", resp_dc_o); end
    n_cmp++; if (req_ready_o !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready got=%b want=1", req_ready_o); end
    @(negedge clk_i);
    rst_ni = 1'b1;
    step();
    $display("txn reset released");
  endtask

  task automatic test_inval_priority();
    inval_valid_i = 1'b1; inval_dv_i = 1'b1; inval_did_i = 24'h05;
    req_valid_i = 1'b1; req_did_i = 24'h03; lu_hit_i = 1'b1; lu_content_i = HIT_DC;
    @(negedge clk_i);
    n_cmp++; if (flush_o !== 1'b1) begin n_bad++; $display("FAIL inval_flush got=%b want=1", flush_o); end
    n_cmp++; if (flush_did_o !== 24'h05 || flush_dv_o !== 1'b1) begin n_bad++; $display("FAIL inval_flush_args got=%h/%b want=05/1", flush_did_o, flush_dv_o); end
    n_cmp++; if (req_ready_o !== 1'b0) begin n_bad++; $display("FAIL inval_req_blocked got=%b want=0", req_ready_o); end
    step();
    inval_valid_i = 1'b0;
    @(negedge clk_i);
    n_cmp++; if (flush_o !== 1'b0) begin n_bad++; $display("FAIL inval_one_pulse got=%b want=0", flush_o); end
    n_cmp++; if (req_ready_o !== 1'b1) begin n_bad++; $display("FAIL inval_req_next got=%b want=1", req_ready_o); end
    step();
    req_valid_i = 1'b0;
    @(negedge clk_i);
    n_cmp++; if (lookup_o !== 1'b1 || lu_did_o !== 24'h03) begin n_bad++; $display("FAIL inval_then_lookup got=%b/%h want=1/03", lookup_o, lu_did_o); end
    step();
    resp_ready_i = 1'b1;
    step();
    resp_ready_i = 1'b0;
    lu_hit_i = 1'b0;
    $display("txn inval did=05 then req did=03");
  endtask

  task automatic test_hit();
    lu_hit_i = 1'b1; lu_content_i = HIT_DC;
    issue_req(24'h03);
    @(negedge clk_i);
    n_cmp++; if (lookup_o !== 1'b1 || lu_did_o !== 24'h03) begin n_bad++; $display("FAIL hit_lookup got=%b/%h want=1/03", lookup_o, lu_did_o); end
    n_cmp++; if (resp_valid_o !== 1'b0) begin n_bad++; $display("FAIL hit_early_resp got=%b want=0", resp_valid_o); end
    step();
    lu_hit_i = 1'b0; lu_content_i = '0;
    @(negedge clk_i);
    n_cmp++; if (resp_valid_o !== 1'b1) begin n_bad++; $display("FAIL hit_resp_valid got=%b want=1", resp_valid_o); end
    n_cmp++; if (resp_dc_o !== HIT_DC) begin n_bad++; $display("FAIL hit_resp_dc got=%h want=%h", resp_dc_o, HIT_DC); end
    n_cmp++; if (resp_fault_o !== 1'b0 || resp_cause_o !== 12'd0) begin n_bad++; $display("FAIL hit_fault got=%b/%0d want=0/0", resp_fault_o, resp_cause_o); end
    n_cmp++; if (mem_ar_valid_o !== 1'b0 || update_o !== 1'b0) begin n_bad++; $display("FAIL hit_no_walk got=%b/%b want=0/0", mem_ar_valid_o, update_o); end
    resp_ready_i = 1'b1;
    step();
    resp_ready_i = 1'b0;
    $display("txn hit did=03");
  endtask

  task automatic test_miss();
    logic [DC_W-1:0] exp_dc;
    beat_words[0] = 64'h1111_2222_3333_4401;
    beat_words[1] = 64'h5555_6666_7777_8802;
    beat_words[2] = 64'h9999_AAAA_BBBB_CC03;
    beat_words[3] = 64'hDDDD_EEEE_FFFF_0004;
    exp_dc = {beat_words[3], beat_words[2], beat_words[1], beat_words[0]};
    err_beat = -1;
    issue_req(24'h10);
    @(negedge clk_i);
    n_cmp++; if (lookup_o !== 1'b1 || mem_ar_valid_o !== 1'b0) begin n_bad++; $display("FAIL miss_lookup got=%b/%b want=1/0", lookup_o, mem_ar_valid_o); end
    step();
    @(negedge clk_i);
    n_cmp++; if (mem_ar_valid_o !== 1'b1) begin n_bad++; $display("FAIL miss_ar_valid got=%b want=1", mem_ar_valid_o); end
    n_cmp++; if (mem_ar_addr_o !== 56'h8000_0200) begin n_bad++; $display("FAIL miss_ar_addr got=%h want=80000200", mem_ar_addr_o); end
    n_cmp++; if (mem_ar_len_o !== 8'd3) begin n_bad++; $display("FAIL miss_ar_len got=%0d want=3", mem_ar_len_o); end
    step();
    @(negedge clk_i);
    n_cmp++; if (mem_ar_valid_o !== 1'b1 || mem_ar_addr_o !== 56'h8000_0200) begin n_bad++; $display("FAIL miss_ar_hold got=%b/%h want=1/80000200", mem_ar_valid_o, mem_ar_addr_o); end
    mem_ar_ready_i = 1'b1;
    step();
    mem_ar_ready_i = 1'b0;
    @(negedge clk_i);
    n_cmp++; if (mem_r_ready_o !== 1'b1) begin n_bad++; $display("FAIL miss_r_ready got=%b want=1", mem_r_ready_o); end
    drive_beats();
    @(negedge clk_i);
    n_cmp++; if (update_o !== 1'b1 || up_did_o !== 24'h10) begin n_bad++; $display("FAIL miss_update got=%b/%h want=1/10", update_o, up_did_o); end
    n_cmp++; if (up_content_o !== exp_dc) begin n_bad++; $display("FAIL miss_up_content got=%h want=%h", up_content_o, exp_dc); end
    step();
    @(negedge clk_i);
    n_cmp++; if (resp_valid_o !== 1'b1 || resp_dc_o !== exp_dc || resp_fault_o !== 1'b0) begin n_bad++; $display("FAIL miss_resp got=%b/%h/%b want=1/%h/0", resp_valid_o, resp_dc_o, resp_fault_o, exp_dc); end
    resp_ready_i = 1'b1;
    step();
    resp_ready_i = 1'b0;
    $display("txn miss did=10 filled");
  endtask

  // Walk that reaches the response without filling the DDTC; checks fault cause and zeroed DC.
  task automatic test_walk_fault(input logic [23:0] did, input logic [PA_W-1:0] exp_addr,
                                 input logic [11:0] exp_cause, input string tag);
    issue_req(did);
    step();
    @(negedge clk_i);
    n_cmp++; if (mem_ar_addr_o !== exp_addr) begin n_bad++; $display("FAIL %s_ar_addr got=%h want=%h", tag, mem_ar_addr_o, exp_addr); end
    mem_ar_ready_i = 1'b1;
    step();
    mem_ar_ready_i = 1'b0;
    drive_beats();
    @(negedge clk_i);
    n_cmp++; if (update_o !== 1'b0) begin n_bad++; $display("FAIL %s_no_update got=%b want=0", tag, update_o); end
    n_cmp++; if (resp_valid_o !== 1'b1 || resp_fault_o !== 1'b1 || resp_cause_o !== exp_cause) begin n_bad++; $display("FAIL %s_resp got=%b/%b/%0d want=1/1/%0d", tag, resp_valid_o, resp_fault_o, resp_cause_o, exp_cause); end
    n_cmp++; if (resp_dc_o !== '0) begin n_bad++; $display("FAIL %s_dc_zero got=%h want=0", tag, resp_dc_o); end
    resp_ready_i = 1'b1;
    step();
    resp_ready_i = 1'b0;
    $display("txn %s did=%h cause=%0d", tag, did, exp_cause);
  endtask

  task automatic test_did_range();
    lu_hit_i = 1'b1; lu_content_i = HIT_DC;
    issue_req(24'h80);
    @(negedge clk_i);
    n_cmp++; if (mem_ar_valid_o !== 1'b0 || resp_valid_o !== 1'b0) begin n_bad++; $display("FAIL range_n1 got=%b/%b want=0/0", mem_ar_valid_o, resp_valid_o); end
    step();
    lu_hit_i = 1'b0;
    @(negedge clk_i);
    n_cmp++; if (resp_valid_o !== 1'b1 || resp_fault_o !== 1'b1 || resp_cause_o !== 12'd258) begin n_bad++; $display("FAIL range_resp got=%b/%b/%0d want=1/1/258", resp_valid_o, resp_fault_o, resp_cause_o); end
    n_cmp++; if (resp_dc_o !== '0 || mem_ar_valid_o !== 1'b0) begin n_bad++; $display("FAIL range_dc_mem got=%h/%b want=0/0", resp_dc_o, mem_ar_valid_o); end
    resp_ready_i = 1'b1;
    step();
    resp_ready_i = 1'b0;
    $display("txn did=80 out of range");
  endtask

  task automatic test_back_to_back_stall();
    lu_hit_i = 1'b1; lu_content_i = HIT_DC;
    issue_req(24'h07);
    step();
    lu_hit_i = 1'b0; lu_content_i = '0;
    inval_valid_i = 1'b1; inval_dv_i = 1'b0; inval_did_i = 24'h07;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      n_cmp++; if (resp_valid_o !== 1'b1 || resp_dc_o !== HIT_DC) begin n_bad++; $display("FAIL stall_resp_%0d got=%b/%h want=1/%h", i, resp_valid_o, resp_dc_o, HIT_DC); end
      n_cmp++; if (inval_ready_o !== 1'b0 || flush_o !== 1'b0) begin n_bad++; $display("FAIL stall_inval_%0d got=%b/%b want=0/0", i, inval_ready_o, flush_o); end
      step();
    end
    resp_ready_i = 1'b1;
    step();
    resp_ready_i = 1'b0;
    @(negedge clk_i);
    n_cmp++; if (flush_o !== 1'b1 || flush_did_o !== 24'h07 || flush_dv_o !== 1'b0) begin n_bad++; $display("FAIL stall_flush_after got=%b/%h/%b want=1/07/0", flush_o, flush_did_o, flush_dv_o); end
    step();
    inval_valid_i = 1'b0;
    $display("txn stalled resp did=07 then inval");
  endtask

  task automatic test_reset_midwalk();
    issue_req(24'h12);
    step();
    @(negedge clk_i);
    n_cmp++; if (mem_ar_valid_o !== 1'b1) begin n_bad++; $display("FAIL abort_pre got=%b want=1", mem_ar_valid_o); end
    rst_ni = 1'b0;
    #1;
    n_cmp++; if (mem_ar_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin n_bad++; $display("FAIL abort_idle got=%b/%b want=0/1", mem_ar_valid_o, req_ready_o); end
    step();
    rst_ni = 1'b1;
    step();
    $display("txn reset during walk did=12");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_inval_priority();
    test_hit();
    test_miss();
    beat_words[0] = 64'h0000_0000_0000_0011;
    beat_words[1] = 64'h0000_0000_0000_0022;
    beat_words[2] = 64'h0000_0000_0000_0033;
    beat_words[3] = 64'h0000_0000_0000_0044;
    err_beat = 2;
    test_walk_fault(24'h11, 56'h8000_0220, 12'd257, "rd_err");
    beat_words[0] = 64'hFFFF_FFFF_FFFF_FFFE;
    err_beat = -1;
    test_walk_fault(24'h20, 56'h8000_0400, 12'd258, "dc_invalid");
    test_did_range();
    test_back_to_back_stall();
    test_reset_midwalk();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
